mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: max consecutive data-port grants while instruction port waits.
REQ-002 Parameter TIMEOUT, default 255: max BUSY cycles without m_ack before abort; legal range 1..255.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 rst  in  1  reset, synchronous, active-low; sampled only on posedge clk.
REQ-005 i_req  in  1  instruction-port read request, held until i_ack.
REQ-006 i_addr  in  32  instruction read address, stable while i_req high.
REQ-007 i_ack  out  1  one-cycle completion pulse, instruction port.
REQ-008 i_err  out  1  error flag, valid only with i_ack.
REQ-009 i_rdata  out  32  read data, valid only with i_ack.
REQ-010 d_req  in  1  data-port request, held until d_ack.
REQ-011 d_we  in  1  1 = write, 0 = read.
REQ-012 d_addr  in  32  data address.
REQ-013 d_wdata  in  32  write data.
REQ-014 d_wstrb  in  4  byte write strobes.
REQ-015 d_ack  out  1  one-cycle completion pulse, data port.
REQ-016 d_err  out  1  error flag, valid only with d_ack.
REQ-017 d_rdata  out  32  read data, valid with d_ack; 0 for writes.
REQ-018 m_req  out  1  request to shared memory, held until m_ack or abort.
REQ-019 m_we, m_addr, m_wdata, m_wstrb  out  1/32/32/4  registered copies of the granted request; instruction grants drive m_we=0, m_wstrb=0, m_wdata=0.
REQ-020 m_ack  in  1  memory completion; m_rdata/m_err valid in the same cycle.
REQ-021 m_rdata  in  32  memory read data.
REQ-022 m_err  in  1  memory error.
REQ-023 m_owner  out  1  0 = instruction, 1 = data; identifies the current grant.

Function
REQ-024 FSM states IDLE, BUSY, RESP; all outputs registered.
REQ-025 IDLE: when any request is high, latch the winner's fields, set m_owner, and enter BUSY with m_req=1 on the next edge.
REQ-026 Arbitration: data port wins by default; instruction port wins when both request and starve_cnt == STARVE_LIMIT.
REQ-027 starve_cnt: increments on a data grant with i_req high; clears on an instruction grant or on a data grant with i_req low; saturates at STARVE_LIMIT.
REQ-028 BUSY: m_req and the m_* fields stay constant; the cycle counter increments each BUSY cycle without m_ack.
REQ-029 BUSY with m_ack=1: drop m_req, register m_rdata (0 for writes) and m_err into the owner's rdata/err, enter RESP.
REQ-030 BUSY timeout: when the TIMEOUT-th BUSY cycle has no m_ack, drop m_req, set err=1 and rdata=0, enter RESP.
REQ-031 Simultaneous m_ack and timeout: m_ack wins and err = m_err.
REQ-032 RESP: the owner's ack is high for exactly 1 cycle with rdata/err; next state is IDLE unconditionally.
REQ-033 Requests are not sampled in BUSY or RESP; a requester deasserts or re-presents its request in the cycle after its ack.
REQ-034 m_ack is ignored in IDLE and RESP, so stray or late acks have no effect.
REQ-035 Latency: request sampled in IDLE at cycle T gives m_req at T+1; m_ack at cycle A gives port ack at A+1; minimum 2 cycles.
REQ-036 Non-owner ack/err/rdata stay 0; i_ack and d_ack are never high together.
REQ-037 Back-to-back: at most one transaction in flight; a new grant occurs no earlier than the IDLE cycle after RESP.

Reset
REQ-038 While rst=0 at a clock edge: state <= IDLE; all outputs, starve_cnt and the cycle counter <= 0.
REQ-039 Reset mid-transaction: m_req drops on that edge, the transaction is discarded with no ack, and a later m_ack is ignored.
REQ-040 First grant is possible in the first cycle after rst returns high.

Verification
REQ-041 i_req=1, i_addr=0x1000, m_ack returned the same cycle m_req rises with m_rdata=0xDEADBEEF -> i_ack=1 and i_rdata=0xDEADBEEF exactly 2 cycles after the request is sampled; m_we=0.
REQ-042 d_req write with addr 0x2004, wdata 0x12345678, wstrb 0xF, m_ack after 3 wait cycles -> m_* fields held constant for 4 cycles; d_ack=1, d_rdata=0, d_err=0.
REQ-043 i_req and d_req held continuously, STARVE_LIMIT=4 -> grant sequence D,D,D,D,I,D,D,D,D,I; m_owner matches each grant.
REQ-044 d_req with m_ack never asserted, TIMEOUT=8 -> m_req high for exactly 8 cycles, then d_ack=1 with d_err=1 and d_rdata=0.
REQ-045 rst=0 asserted during BUSY, then m_ack pulsed after rst returns high with no request pending -> no ack on either port; all outputs 0; state IDLE.
REQ-046 m_ack coincident with the final timeout cycle, m_err=0, m_rdata=0x55 -> ack with err=0 and rdata=0x55.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port (instruction/data) arbiter onto a single shared memory port.
// One transaction in flight; data port preferred, instruction port protected from starvation.
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ack,
    output logic        i_err,
    output logic [31:0] i_rdata,

    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wstrb,
    output logic        d_ack,
    output logic        d_err,
    output logic [31:0] d_rdata,

    output logic        m_req,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_wstrb,
    input  logic        m_ack,
    input  logic [31:0] m_rdata,
    input  logic        m_err,
    output logic        m_owner,

    output logic [1:0]  o_state
);

    // Handshake: each port holds req (and its fields) until its one-cycle ack;
    // m_req is held until m_ack or the BUSY timeout, whichever comes first.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam int            SW         = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [7:0]    CNT_LAST   = 8'(TIMEOUT - 1);

    state_t        r_state;
    logic [SW-1:0] r_starve;
    logic [7:0]    r_cnt;

    logic          r_i_ack;
    logic          r_i_err;
    logic [31:0]   r_i_rdata;
    logic          r_d_ack;
    logic          r_d_err;
    logic [31:0]   r_d_rdata;
    logic          r_m_req;
    logic          r_m_we;
    logic [31:0]   r_m_addr;
    logic [31:0]   r_m_wdata;
    logic [3:0]    r_m_wstrb;
    logic          r_m_owner;

    logic          w_pick_i;
    logic [31:0]   w_ack_rdata;

    // Instruction wins only when data is absent or the starvation limit is reached.
    assign w_pick_i    = i_req && (!d_req || (r_starve == STARVE_MAX));
    assign w_ack_rdata = r_m_we ? 32'h0 : m_rdata;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_starve  <= '0;
            r_cnt     <= '0;
            r_i_ack   <= 1'b0;
            r_i_err   <= 1'b0;
            r_i_rdata <= '0;
            r_d_ack   <= 1'b0;
            r_d_err   <= 1'b0;
            r_d_rdata <= '0;
            r_m_req   <= 1'b0;
            r_m_we    <= 1'b0;
            r_m_addr  <= '0;
            r_m_wdata <= '0;
            r_m_wstrb <= '0;
            r_m_owner <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_req || d_req) begin
                        r_m_req <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= S_BUSY;
                        if (w_pick_i) begin
                            r_m_owner <= 1'b0;
                            r_m_we    <= 1'b0;
                            r_m_addr  <= i_addr;
                            r_m_wdata <= '0;
                            r_m_wstrb <= '0;
                            r_starve  <= '0;
                        end else begin
                            r_m_owner <= 1'b1;
                            r_m_we    <= d_we;
                            r_m_addr  <= d_addr;
                            r_m_wdata <= d_wdata;
                            r_m_wstrb <= d_wstrb;
                            if (!i_req) begin
                                r_starve <= '0;
                            end else if (r_starve != STARVE_MAX) begin
                                r_starve <= r_starve + 1'b1;
                            end
                        end
                    end
                end

                S_BUSY: begin
                    // m_ack takes priority over a timeout landing in the same cycle.
                    if (m_ack) begin
                        r_m_req <= 1'b0;
                        r_state <= S_RESP;
                        if (r_m_owner) begin
                            r_d_ack   <= 1'b1;
                            r_d_err   <= m_err;
                            r_d_rdata <= w_ack_rdata;
                        end else begin
                            r_i_ack   <= 1'b1;
                            r_i_err   <= m_err;
                            r_i_rdata <= w_ack_rdata;
                        end
                    end else if (r_cnt == CNT_LAST) begin
                        r_m_req <= 1'b0;
                        r_state <= S_RESP;
                        if (r_m_owner) begin
                            r_d_ack   <= 1'b1;
                            r_d_err   <= 1'b1;
                            r_d_rdata <= '0;
                        end else begin
                            r_i_ack   <= 1'b1;
                            r_i_err   <= 1'b1;
                            r_i_rdata <= '0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                S_RESP: begin
                    r_i_ack   <= 1'b0;
                    r_i_err   <= 1'b0;
                    r_i_rdata <= '0;
                    r_d_ack   <= 1'b0;
                    r_d_err   <= 1'b0;
                    r_d_rdata <= '0;
                    r_state   <= S_IDLE;
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign i_ack   = r_i_ack;
    assign i_err   = r_i_err;
    assign i_rdata = r_i_rdata;
    assign d_ack   = r_d_ack;
    assign d_err   = r_d_err;
    assign d_rdata = r_d_rdata;
    assign m_req   = r_m_req;
    assign m_we    = r_m_we;
    assign m_addr  = r_m_addr;
    assign m_wdata = r_m_wdata;
    assign m_wstrb = r_m_wstrb;
    assign m_owner = r_m_owner;
    assign o_state = r_state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed corner transactions plus randomized
// request/ack timing checked against a transaction-level arbitration model.
module tb_mem_arbiter;

    localparam int STARVE_LIMIT = 4;
    localparam int TIMEOUT      = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = '0;
    logic        i_ack;
    logic        i_err;
    logic [31:0] i_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [3:0]  d_wstrb = '0;
    logic        d_ack;
    logic        d_err;
    logic [31:0] d_rdata;
    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic        m_ack = 1'b0;
    logic [31:0] m_rdata = '0;
    logic        m_err = 1'b0;
    logic        m_owner;
    logic [1:0]  o_state;

    mem_arbiter #(
        .STARVE_LIMIT(STARVE_LIMIT),
        .TIMEOUT     (TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_err(i_err), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
        .d_ack(d_ack), .d_err(d_err), .d_rdata(d_rdata),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_ack(m_ack), .m_rdata(m_rdata), .m_err(m_err), .m_owner(m_owner),
        .o_state(o_state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: pending request per port, starvation count, expected completions {owner, err, rdata}.
    bit          pi = 1'b0;
    bit          pd = 1'b0;
    logic [31:0] ia = '0;
    logic [31:0] da = '0;
    logic [31:0] dwd = '0;
    logic        dwe = 1'b0;
    logic [3:0]  dws = '0;
    int          starve_m = 0;
    logic [33:0] exp_q[$];
    bit          obs_log[$];
    int          seq_exp[10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_m_req"},   32'(m_req),   32'd0);
        check_eq({tag, "_m_we"},    32'(m_we),    32'd0);
        check_eq({tag, "_m_addr"},  m_addr,       32'd0);
        check_eq({tag, "_m_wdata"}, m_wdata,      32'd0);
        check_eq({tag, "_m_wstrb"}, 32'(m_wstrb), 32'd0);
        check_eq({tag, "_m_owner"}, 32'(m_owner), 32'd0);
        check_eq({tag, "_i_ack"},   32'(i_ack),   32'd0);
        check_eq({tag, "_i_err"},   32'(i_err),   32'd0);
        check_eq({tag, "_i_rdata"}, i_rdata,      32'd0);
        check_eq({tag, "_d_ack"},   32'(d_ack),   32'd0);
        check_eq({tag, "_d_err"},   32'(d_err),   32'd0);
        check_eq({tag, "_d_rdata"}, d_rdata,      32'd0);
        check_eq({tag, "_state"},   32'(o_state), 32'd0);
    endtask

    task automatic drive_ports();
        i_req   = pi;
        i_addr  = ia;
        d_req   = pd;
        d_we    = dwe;
        d_addr  = da;
        d_wdata = dwd;
        d_wstrb = dws;
    endtask

    task automatic new_reqs(input bit force_both);
        if (!pi && (force_both || $urandom_range(0, 2) != 0)) begin
            pi = 1'b1;
            ia = $urandom;
        end
        if (!pd && (force_both || $urandom_range(0, 2) != 0)) begin
            pd  = 1'b1;
            dwe = 1'($urandom_range(0, 1));
            da  = $urandom;
            dwd = $urandom;
            dws = 4'($urandom_range(0, 15));
        end
    endtask

    // Called at a negedge while the arbiter is idle; returns at the negedge of the next idle cycle.
    task automatic run_slot(input int k_force, input bit rd_use, input logic [31:0] rd_val);
        bit          own;
        logic [31:0] ea;
        logic [31:0] ewd;
        logic        ewe;
        logic [3:0]  ews;
        logic [33:0] e;
        int          k;
        drive_ports();
        m_ack   = 1'($urandom_range(0, 1));
        m_rdata = $urandom;
        m_err   = 1'($urandom_range(0, 1));
        if (!pi && !pd) begin
            @(negedge clk);
            m_ack = 1'b0;
            check_eq("idle_m_req", 32'(m_req), 32'd0);
            check_eq("idle_i_ack", 32'(i_ack), 32'd0);
            check_eq("idle_d_ack", 32'(d_ack), 32'd0);
            return;
        end
        if (pd && !(pi && starve_m == STARVE_LIMIT)) begin
            own = 1'b1; ea = da; ewe = dwe; ewd = dwd; ews = dws;
            if (!pi) starve_m = 0;
            else if (starve_m < STARVE_LIMIT) starve_m++;
        end else begin
            own = 1'b0; ea = ia; ewe = 1'b0; ewd = 32'h0; ews = 4'h0;
            starve_m = 0;
        end
        k = (k_force >= 0) ? k_force : $urandom_range(0, TIMEOUT + 2);
        e = {own, 1'b1, 32'h0};
        for (int j = 0; j < TIMEOUT; j++) begin
            @(negedge clk);
            if (j == 0) obs_log.push_back(m_owner);
            check_eq("busy_m_req",   32'(m_req),   32'd1);
            check_eq("busy_m_owner", 32'(m_owner), 32'(own));
            check_eq("busy_m_addr",  m_addr,       ea);
            check_eq("busy_m_we",    32'(m_we),    32'(ewe));
            check_eq("busy_m_wdata", m_wdata,      ewd);
            check_eq("busy_m_wstrb", 32'(m_wstrb), 32'(ews));
            check_eq("busy_i_ack",   32'(i_ack),   32'd0);
            check_eq("busy_d_ack",   32'(d_ack),   32'd0);
            m_rdata = rd_use ? rd_val : $urandom;
            m_err   = rd_use ? 1'b0 : 1'($urandom_range(0, 1));
            if (j == k) begin
                m_ack = 1'b1;
                e = {own, m_err, (ewe ? 32'h0 : m_rdata)};
                break;
            end
            m_ack = 1'b0;
        end
        exp_q.push_back(e);

        @(negedge clk);
        m_ack = 1'($urandom_range(0, 1));
        e = exp_q.pop_front();
        check_eq("resp_m_req", 32'(m_req), 32'd0);
        if (e[33]) begin
            check_eq("resp_d_ack",   32'(d_ack), 32'd1);
            check_eq("resp_d_err",   32'(d_err), 32'(e[32]));
            check_eq("resp_d_rdata", d_rdata,    e[31:0]);
            check_eq("resp_i_ack",   32'(i_ack), 32'd0);
            check_eq("resp_i_err",   32'(i_err), 32'd0);
            check_eq("resp_i_rdata", i_rdata,    32'd0);
            pd = 1'b0;
        end else begin
            check_eq("resp_i_ack",   32'(i_ack), 32'd1);
            check_eq("resp_i_err",   32'(i_err), 32'(e[32]));
            check_eq("resp_i_rdata", i_rdata,    e[31:0]);
            check_eq("resp_d_ack",   32'(d_ack), 32'd0);
            check_eq("resp_d_err",   32'(d_err), 32'd0);
            check_eq("resp_d_rdata", d_rdata,    32'd0);
            pi = 1'b0;
        end

        @(negedge clk);
        m_ack = 1'b0;
        check_eq("post_m_req", 32'(m_req), 32'd0);
        check_eq("post_i_ack", 32'(i_ack), 32'd0);
        check_eq("post_d_ack", 32'(d_ack), 32'd0);
    endtask

    initial begin
        drive_ports();
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b1;

        // Instruction read acked immediately; first grant right after reset release.
        pi = 1'b1; ia = 32'h1000;
        run_slot(0, 1'b1, 32'hDEADBEEF);

        // Data write with three wait cycles.
        pd = 1'b1; dwe = 1'b1; da = 32'h2004; dwd = 32'h12345678; dws = 4'hF;
        run_slot(3, 1'b1, 32'hA5A5A5A5);

        // Data read that never sees m_ack: timeout.
        pd = 1'b1; dwe = 1'b0; da = $urandom; dwd = $urandom; dws = 4'h3;
        run_slot(TIMEOUT + 5, 1'b0, 32'h0);

        // m_ack lands on the final timeout cycle.
        pi = 1'b1; ia = $urandom;
        run_slot(TIMEOUT - 1, 1'b1, 32'h55);

        // Reset in the middle of a data grant taken while the instruction port waits.
        pi = 1'b1; ia = $urandom; pd = 1'b1; dwe = 1'b0; da = $urandom;
        drive_ports();
        m_ack = 1'b0;
        @(negedge clk);
        check_eq("rst_pre_m_req",   32'(m_req),   32'd1);
        check_eq("rst_pre_m_owner", 32'(m_owner), 32'd1);
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("rst_mid");
        rst = 1'b1;
        pi = 1'b0; pd = 1'b0;
        drive_ports();
        m_ack = 1'b1; m_rdata = $urandom; m_err = 1'b1;
        @(negedge clk);
        m_ack = 1'b0;
        check_all_zero("rst_late_ack");
        @(negedge clk);
        check_all_zero("rst_after");
        starve_m = 0;

        // Both ports held: data wins STARVE_LIMIT times, then instruction.
        obs_log.delete();
        for (int n = 0; n < 10; n++) begin
            new_reqs(1'b1);
            run_slot(-1, 1'b0, 32'h0);
        end
        check_eq("starve_len", 32'(obs_log.size()), 32'd10);
        for (int n = 0; n < 10 && n < obs_log.size(); n++) begin
            check_eq($sformatf("starve_seq_%0d", n), 32'(obs_log[n]), 32'(seq_exp[n]));
        end

        for (int n = 0; n < 80; n++) begin
            new_reqs(1'b0);
            run_slot(-1, 1'b0, 32'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
